// File: rtl/aes_key_sched_param.sv
// AES key expansion (128/192/256) into a round-key store with indexed forward/inverse reads.
// Latency: Nw-Nk cycles to expand after an accepted start; round-key read data one cycle after rd_en.
// Backpressure: none; start is ignored while expanding and rejected (cfg_err) for unsupported lengths.

module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = x;
      for (int b = 0; b < 8; b++) begin
         if (y[b]) acc = acc ^ p;
         p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   logic [7:0] pw;
   logic [7:0] inv;

   // Multiplicative inverse as a^254 = prod a^(2^k), k=1..7; zero maps to zero naturally.
   always_comb begin
      pw  = a_i;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
   end

   assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_key_sched_param #(
   parameter int MAX_NK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         ready,
   output logic         done,
   output logic         cfg_err,
   output logic [3:0]   nr_o,
   input  logic         rd_en,
   input  logic [3:0]   rd_round,
   input  logic         rd_inv,
   output logic         rk_valid,
   output logic [127:0] rk_o,
   output logic         rk_err
);

   localparam int         NW_MAX   = 4 * (MAX_NK + 7);
   localparam int         AW       = $clog2(NW_MAX);
   localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   logic [31:0]   w_q [NW_MAX];
   state_t        state_q;
   logic [3:0]    nk_q;
   logic [3:0]    nr_q;
   logic [AW-1:0] i_q;
   logic [AW-1:0] nwl_q;
   logic [2:0]    phase_q;
   logic [7:0]    rcon_q;
   logic          busy_q, ready_q, done_q, cfg_err_q;
   logic          rk_valid_q, rk_err_q;
   logic [127:0]  rk_q;

   // Key-length decode for the incoming request.
   logic [3:0]    nk_sel;
   logic [AW-1:0] nwl_sel;
   logic          len_ok, can_start, accept, reject;

   // Decode Nk and the index of the last schedule word from key_len.
   always_comb begin
      nk_sel  = 4'd4;
      nwl_sel = AW'(43);
      case (key_len)
         2'b01: begin nk_sel = 4'd6; nwl_sel = AW'(51); end
         2'b10: begin nk_sel = 4'd8; nwl_sel = AW'(59); end
         default: ;
      endcase
   end

   assign len_ok    = (key_len != 2'b11) && (nk_sel <= MAX_NK_W);
   assign can_start = start && (state_q == IDLE || state_q == READY);
   assign accept    = can_start && len_ok;
   assign reject    = can_start && !len_ok;

   // Expansion datapath: one new word w[i] per cycle from w[i-1] and w[i-Nk].
   logic [31:0] prev_w, back_w, sub_in, sub_out, temp, word_d;
   logic        ph_zero, ph_four;

   assign prev_w  = w_q[i_q - AW'(1)];
   assign back_w  = w_q[i_q - AW'(nk_q)];
   assign ph_zero = (phase_q == 3'd0);
   assign ph_four = (nk_q == 4'd8) && (phase_q == 3'd4);
   assign sub_in  = ph_zero ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .a_i (sub_in[8*b +: 8]),
         .s_o (sub_out[8*b +: 8])
      );
   end

   assign temp   = ph_zero ? (sub_out ^ {rcon_q, 24'h0}) : (ph_four ? sub_out : prev_w);
   assign word_d = back_w ^ temp;

   // Round-key read: forward or decryption order, served only from a complete schedule.
   logic [3:0]    rd_k;
   logic [AW-1:0] rd_base;
   logic          rd_ok;

   assign rd_k    = rd_inv ? (nr_q - rd_round) : rd_round;
   assign rd_base = AW'({rd_k, 2'b00});
   assign rd_ok   = (state_q == READY) && !accept && (rd_round <= nr_q);

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Schedule storage: cipher key words on accept, then one expanded word per EXPAND cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) begin
            for (int j = 0; j < MAX_NK; j++) begin
               if (j < int'(nk_sel)) w_q[AW'(j)] <= key_in[255 - 32*j -: 32];
            end
         end else if (state_q == EXPAND) begin
            w_q[i_q] <= word_d;
         end
      end
   end

   // Control FSM with registered status and read-response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
         nr_q       <= 4'd0;
         nk_q       <= 4'd0;
         i_q        <= '0;
         nwl_q      <= '0;
         phase_q    <= 3'd0;
         rcon_q     <= 8'h01;
         rk_valid_q <= 1'b0;
         rk_err_q   <= 1'b0;
         rk_q       <= '0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= reject;

         if (rd_en) begin
            rk_valid_q <= 1'b1;
            if (rd_ok) begin
               rk_err_q <= 1'b0;
               rk_q     <= {w_q[rd_base], w_q[rd_base + AW'(1)],
                            w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};
            end else begin
               rk_err_q <= 1'b1;
               rk_q     <= '0;
            end
         end else begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
         end

         case (state_q)
            IDLE, READY: begin
               if (accept) begin
                  state_q <= EXPAND;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  nk_q    <= nk_sel;
                  nr_q    <= nk_sel + 4'd6;
                  i_q     <= AW'(nk_sel);
                  nwl_q   <= nwl_sel;
                  phase_q <= 3'd0;
                  rcon_q  <= 8'h01;
               end
            end
            EXPAND: begin
               i_q     <= i_q + AW'(1);
               phase_q <= ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
               if (ph_zero) rcon_q <= xtime(rcon_q);
               if (i_q == nwl_q) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign ready    = ready_q;
   assign done     = done_q;
   assign cfg_err  = cfg_err_q;
   assign nr_o     = nr_q;
   assign rk_valid = rk_valid_q;
   assign rk_err   = rk_err_q;
   assign rk_o     = rk_q;

endmodule

// File: tb/tb_aes_key_sched_param.sv
module tb_aes_key_sched_param;

   localparam int MAX_NK = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy, ready, done, cfg_err;
   logic [3:0]   nr_o;
   logic         rd_en;
   logic [3:0]   rd_round;
   logic         rd_inv;
   logic         rk_valid;
   logic [127:0] rk_o;
   logic         rk_err;

   always #5 clk = ~clk;

   aes_key_sched_param #(.MAX_NK(MAX_NK)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_len  (key_len),
      .key_in   (key_in),
      .busy     (busy),
      .ready    (ready),
      .done     (done),
      .cfg_err  (cfg_err),
      .nr_o     (nr_o),
      .rd_en    (rd_en),
      .rd_round (rd_round),
      .rd_inv   (rd_inv),
      .rk_valid (rk_valid),
      .rk_o     (rk_o),
      .rk_err   (rk_err)
   );

   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   logic [7:0] sbox_tab [256];
   logic [7:0] rcon_tab [10];

   // Expected-output state of the reference model.
   logic         e_busy = 1'b0, e_ready = 1'b0, e_done = 1'b0, e_cfg = 1'b0;
   logic         e_rkv = 1'b0, e_rke = 1'b0;
   logic [127:0] e_rko = '0;
   int           m_nr = 0, m_nk = 4, m_left = 0;
   logic [255:0] m_key = '0;

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r = r ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return r;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
   endfunction

   // Full FIPS-197 expansion, returning round key k.
   function automatic logic [127:0] model_rk(input logic [255:0] key, input int nk, input int k);
      logic [31:0] w [60];
      logic [31:0] t;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         t = w[i-1];
         if (i % nk == 0)
            t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
         else if (nk == 8 && i % 8 == 4)
            t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endfunction

   // Reference model: advances the expected outputs on every rising edge.
   always @(posedge clk) begin : model
      int nk;
      int kk;
      bit legal, can_s, acc, rej;
      if (rst) begin
         e_busy <= 1'b0; e_ready <= 1'b0; e_done <= 1'b0; e_cfg <= 1'b0;
         e_rkv <= 1'b0; e_rke <= 1'b0; e_rko <= '0;
         m_nr <= 0; m_left <= 0;
      end else begin
         nk    = 4 + 2 * int'(key_len);
         legal = (key_len != 2'b11) && (nk <= MAX_NK);
         can_s = start && !e_busy;
         acc   = can_s && legal;
         rej   = can_s && !legal;
         if (rd_en) begin
            e_rkv <= 1'b1;
            if (e_ready && !acc && int'(rd_round) <= m_nr) begin
               kk = rd_inv ? (m_nr - int'(rd_round)) : int'(rd_round);
               e_rko <= model_rk(m_key, m_nk, kk);
               e_rke <= 1'b0;
            end else begin
               e_rko <= '0;
               e_rke <= 1'b1;
            end
         end else begin
            e_rkv <= 1'b0;
         end
         e_done <= 1'b0;
         e_cfg  <= rej;
         if (acc) begin
            e_busy <= 1'b1; e_ready <= 1'b0;
            m_nr <= nk + 6; m_nk <= nk; m_key <= key_in;
            m_left <= 4 * (nk + 7) - nk;
         end else if (e_busy) begin
            if (m_left == 1) begin
               e_busy <= 1'b0; e_ready <= 1'b1; e_done <= 1'b1;
            end
            m_left <= m_left - 1;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("busy", busy, e_busy);
         cmp("ready", ready, e_ready);
         cmp("done", done, e_done);
         cmp("cfg_err", cfg_err, e_cfg);
         cmp("nr_o", nr_o, m_nr);
         cmp("rk_valid", rk_valid, e_rkv);
         cmp("rk_o", rk_o, e_rko);
         if (e_rkv) cmp("rk_err", rk_err, e_rke);
      end
   end

   task automatic rd(input logic [3:0] r, input logic inv, output logic [127:0] d, output logic e);
      @(negedge clk);
      rd_en = 1'b1; rd_round = r; rd_inv = inv;
      @(negedge clk);
      rd_en = 1'b0;
      d = rk_o;
      e = rk_err;
   endtask

   task automatic run_start(input logic [1:0] l, input logic [255:0] k,
                            input int exp_lat, input int exp_busy);
      int lat, bcnt;
      bit got;
      @(negedge clk);
      start = 1'b1; key_len = l; key_in = k;
      lat = 0; bcnt = 0; got = 1'b0;
      for (int c = 1; c <= 200 && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bcnt++;
         if (done) begin got = 1'b1; lat = c; end
      end
      if (!got) begin
         n_checks++; n_err++;
         $display("FAIL done_timeout: no done within 200 cycles, required %0d", exp_lat);
      end else begin
         cmp("done_latency", lat, exp_lat);
         cmp("busy_cycles", bcnt, exp_busy);
      end
   endtask

   initial begin
      logic [127:0] d;
      logic         e;
      logic [7:0]   inv, s, c63;

      rst = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0;
      rd_en = 1'b0; rd_round = 4'd0; rd_inv = 1'b0;

      // S-box by brute-force inverse search plus per-bit affine map.
      c63 = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int b = 0; b < 8; b++)
            s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
         sbox_tab[x] = s;
      end
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

      // Pin the model itself with published values.
      cmp("model_sbox_00", sbox_tab[8'h00], 8'h63);
      cmp("model_sbox_53", sbox_tab[8'h53], 8'hed);
      cmp("model_rk128_r10", model_rk(K128, 4, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;

      // Read before any schedule exists.
      rd(4'd3, 1'b0, d, e);
      cmp("idle_read_err", e, 1'b1);
      cmp("idle_read_dat", d, 128'h0);

      // AES-128 known answer.
      run_start(2'b00, K128, 41, 40);
      cmp("nr128", nr_o, 4'd10);
      rd(4'd10, 1'b0, d, e);
      cmp("rk128_r10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      rd(4'd0, 1'b1, d, e);
      cmp("rk128_inv_r0", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Illegal key length while READY.
      @(negedge clk);
      start = 1'b1; key_len = 2'b11; key_in = {8{$urandom}};
      @(negedge clk);
      start = 1'b0;
      cmp("illegal_cfg_err", cfg_err, 1'b1);
      cmp("illegal_ready_kept", ready, 1'b1);
      rd(4'd10, 1'b0, d, e);
      cmp("rk128_after_reject", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      rd(4'd15, 1'b0, d, e);
      cmp("oor_err", e, 1'b1);
      cmp("oor_dat", d, 128'h0);

      // AES-192 known answer.
      run_start(2'b01, K192, 47, 46);
      cmp("nr192", nr_o, 4'd12);
      rd(4'd12, 1'b0, d, e);
      cmp("rk192_r12", d, 128'ha4970a331a78dc09c418c271e3a41d5d);

      // AES-256 known answer.
      run_start(2'b10, K256, 53, 52);
      cmp("nr256", nr_o, 4'd14);
      rd(4'd14, 1'b0, d, e);
      cmp("rk256_r14", d, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      rd(4'd1, 1'b0, d, e);
      cmp("rk256_r1", d, 128'h101112131415161718191a1b1c1d1e1f);

      // Start during EXPAND is ignored; reset mid-EXPAND kills the schedule.
      @(negedge clk);
      start = 1'b1; key_len = 2'b10; key_in = K256;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; key_len = 2'b00; key_in = {8{$urandom}};
      @(negedge clk);
      start = 1'b0;
      cmp("ignored_start_no_cfg_err", cfg_err, 1'b0);
      cmp("ignored_start_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rd(4'd14, 1'b0, d, e);
      cmp("post_reset_read_err", e, 1'b1);
      run_start(2'b10, K256, 53, 52);
      rd(4'd14, 1'b0, d, e);
      cmp("rk256_again_r14", d, 128'h24fc79ccbf0979e9371ac23c6d68de36);

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 399) == 0);
         start    = ($urandom_range(0, 29) == 0);
         key_len  = 2'($urandom_range(0, 3));
         key_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rd_en    = 1'($urandom_range(0, 1));
         rd_round = 4'($urandom_range(0, 15));
         rd_inv   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; rd_en = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_key_sched_param.md
AES_KEY_SCHED_PARAM -- requirements
Module: aes_key_sched_param

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, giving the largest supported key in 32-bit words (legal values 4, 6, 8); schedule storage depth is 4*(MAX_NK+7) words.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to expand key_in; sampled each cycle.
REQ-005 SHALL have port key_len  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal; sampled with start.
REQ-006 SHALL have port key_in  input  256  cipher key, MSB-aligned: 128-bit in [255:128], 192-bit in [255:64]; word 0 = [255:224].
REQ-007 SHALL have port busy  output  1  expansion in progress.
REQ-008 SHALL have port ready  output  1  complete schedule stored and readable.
REQ-009 SHALL have port done  output  1  one-cycle pulse on the cycle ready rises.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected start.
REQ-011 SHALL have port nr_o  output  4  round count Nr of the stored schedule (10/12/14), 0 when none.
REQ-012 SHALL have port rd_en  input  1  round-key read request.
REQ-013 SHALL have port rd_round  input  4  requested round index r.
REQ-014 SHALL have port rd_inv  input  1  1 = return decryption-order key, round Nr-r.
REQ-015 SHALL have port rk_valid  output  1  read data valid, one cycle after rd_en.
REQ-016 SHALL have port rk_o  output  128  round key {w[4k],w[4k+1],w[4k+2],w[4k+3]}, w[4k] in [127:96].
REQ-017 SHALL have port rk_err  output  1  qualifies rk_valid: read was out of range or not ready.

Function
REQ-018 SHALL implement FSM states IDLE, EXPAND, READY; IDLE->EXPAND and READY->EXPAND on accepted start; EXPAND->READY after the last word is written.
REQ-019 SHALL accept start only in IDLE or READY with legal key_len; start in EXPAND SHALL be ignored without cfg_err.
REQ-020 SHALL reject start with key_len=11 or Nk>MAX_NK: cfg_err pulses next cycle, state and stored schedule unchanged.
REQ-021 SHALL on accepted start write words 0..Nk-1 from key_in, clear ready, set busy, nr_o = Nk+6, total words Nw = 4*(Nk+7).
REQ-022 SHALL produce exactly one word per EXPAND cycle for i = Nk..Nw-1: temp=w[i-1]; if i mod Nk==0, temp=SubWord(RotWord(temp)) xor {Rcon,24'h0}; else if Nk==8 and i mod 8==4, temp=SubWord(temp); w[i]=w[i-Nk] xor temp.
REQ-023 SHALL track i mod Nk with a phase counter (no divider) and Rcon with a register reset to 8'h01 on accept, advanced by GF(2^8) xtime after each use (01,02,...,80,1B,36).
REQ-024 SHALL use exactly four forward S-box instances, shared by both SubWord cases.
REQ-025 SHALL complete in Nw-Nk EXPAND cycles (40/46/52); busy falls and ready, done rise on the cycle after the last word write.
REQ-026 SHALL serve reads only in READY: rd_en with rd_round<=Nr -> next cycle rk_valid=1, rk_err=0, rk_o = key of round k, k = rd_inv ? Nr-rd_round : rd_round.
REQ-027 SHALL on rd_en with rd_round>Nr, or when not READY, give rk_valid=1, rk_err=1, rk_o=0 next cycle.
REQ-028 SHALL drive rk_valid=0 and hold rk_o in cycles following no rd_en.
REQ-029 SHALL treat rd_en and accepted start in the same cycle as start priority: the read returns rk_err=1.

Reset
REQ-030 SHALL on rst (any state, including mid-EXPAND) enter IDLE with busy=0, ready=0, done=0, cfg_err=0, rk_valid=0, rk_err=0, rk_o=0, nr_o=0, Rcon=8'h01; storage contents need not clear.
REQ-031 SHALL require a new start after reset before any read succeeds.

Verification
REQ-032 AES-128 key 000102..0e0f, start -> done 41 cycles later, nr_o=10, read r=10 -> 13111d7fe3944a17f307a78b4d2b30c5; r=0 rd_inv=1 gives same.
REQ-033 AES-192 key 000102..1617 -> 46 EXPAND cycles, nr_o=12, read r=12 -> a4970a331a78dc09c418c271e3a41d5d.
REQ-034 AES-256 key 000102..1e1f -> 52 EXPAND cycles, nr_o=14, read r=14 -> 24fc79ccbf0979e9371ac23c6d68de36; r=1 -> 101112131415161718191a1b1c1d1e1f.
REQ-035 start with key_len=11 in READY -> cfg_err pulse, ready stays 1, prior keys still readable; read r=15 -> rk_err=1, rk_o=0.
REQ-036 rst asserted mid-EXPAND, then read -> rk_err=1; new start with same key -> identical schedule; start during EXPAND ignored.
